output_ts_restore: RTL and testbench

Rebuilds a standard 188-byte MPEG-TS stream from the user-packet byte stream produced on the T2-MI extraction side, undoing the input preparation. In Normal Mode (NM) each incoming packet begins with the CRC-8 of the previous packet's 187 payload bytes; the block checks that CRC and replaces the byte with the sync byte. In High Efficiency Mode (HEM) packets arrive without a sync byte; the block inserts one. Output carries the sync flag and a 1-based byte index for downstream TS output logic.

---
 rtl/output_ts_restore.sv | 141 ++++++++++++++
 tb/tb_output_ts_restore.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_ts_restore.sv
// rtl/output_ts_restore.sv - rebuilds 188-byte MPEG-TS packets from NM/HEM user packets
module output_ts_restore #(
    parameter logic [7:0] SYNC_BYTE = 8'h47,
    parameter int         PKT_LEN   = 188,
    parameter int         BUF_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  DATA_IN,
    input  logic        DVALID_IN,
    input  logic        SOP_IN,
    input  logic        NM_or_HEM,
    output logic [7:0]  DATA_OUT,
    output logic        DVALID_OUT,
    output logic        PSYNC_OUT,
    output logic [7:0]  BYTE_INDEX,
    output logic        CRC_ERR,
    output logic        LEN_ERR,
    output logic        OVF,
    output logic [15:0] CRC_ERR_CNT
);
    localparam int              PW       = $clog2(BUF_DEPTH);
    localparam int              EW       = 17;
    localparam logic [7:0]      LAST_NM  = 8'(PKT_LEN);
    localparam logic [7:0]      LAST_HEM = 8'(PKT_LEN - 1);
    localparam logic [PW+1:0]   DEPTH_L  = (PW+2)'(BUF_DEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {WAIT_SOP, IN_PKT, DONE} state_t;

    state_t        state;
    logic [7:0]    cnt;
    logic          hem;
    logic [7:0]    crc;
    logic          crc_valid;

    logic [EW-1:0] mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   occ;

    logic          sop, accept, short_err, extra_err, ovf, rd, pkt_hem, chk;
    logic [1:0]    need, wr_n;
    logic [PW+1:0] free;
    logic [7:0]    cnt_nx, idx, last;
    logic [EW-1:0] ent0, ent1;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = (r[7] ^ d[i]) ? ({r[6:0], 1'b0} ^ 8'hD5) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    // A valid SOP always starts a packet; only the error reporting depends on state.
    always_comb begin
        sop       = DVALID_IN && SOP_IN;
        accept    = sop || (DVALID_IN && state == IN_PKT);
        short_err = sop && state == IN_PKT;
        extra_err = DVALID_IN && !SOP_IN && state == DONE;
        pkt_hem   = sop ? NM_or_HEM : hem;
        cnt_nx    = sop ? 8'd1 : cnt + 8'd1;
        idx       = pkt_hem ? cnt_nx + 8'd1 : cnt_nx;
        last      = pkt_hem ? LAST_HEM : LAST_NM;
        need      = !accept ? 2'd0 : (sop && NM_or_HEM) ? 2'd2 : 2'd1;
        rd        = occ != '0;
        free      = DEPTH_L - (PW+2)'(occ) + (PW+2)'(rd);
        ovf       = accept && ((PW+2)'(need) > free);
        wr_n      = ovf ? 2'd0 : need;
        ent0      = sop ? {SYNC_BYTE, 1'b1, 8'd1} : {DATA_IN, 1'b0, idx};
        ent1      = {DATA_IN, 1'b0, 8'd2};
        chk       = sop && !NM_or_HEM && crc_valid && state != IN_PKT && !ovf;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= WAIT_SOP;
            cnt         <= '0;
            hem         <= 1'b0;
            crc         <= '0;
            crc_valid   <= 1'b0;
            CRC_ERR     <= 1'b0;
            LEN_ERR     <= 1'b0;
            OVF         <= 1'b0;
            CRC_ERR_CNT <= '0;
        end else begin
            CRC_ERR <= 1'b0;
            LEN_ERR <= short_err || extra_err;
            OVF     <= ovf;
            if (chk && DATA_IN != crc) begin
                CRC_ERR <= 1'b1;
                if (CRC_ERR_CNT != 16'hFFFF) CRC_ERR_CNT <= CRC_ERR_CNT + 16'd1;
            end
            if (ovf || extra_err) begin
                state     <= WAIT_SOP;
                crc_valid <= 1'b0;
            end else if (accept) begin
                cnt <= cnt_nx;
                hem <= pkt_hem;
                // NM SOP byte is the received CRC itself, so it never enters the new CRC
                if (sop) crc <= NM_or_HEM ? crc8_byte(8'h00, DATA_IN) : 8'h00;
                else     crc <= crc8_byte(crc, DATA_IN);
                if (cnt_nx == last) begin
                    state     <= DONE;
                    crc_valid <= !pkt_hem;
                end else begin
                    state <= IN_PKT;
                    if (short_err || (sop && NM_or_HEM)) crc_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_n != 2'd0) mem[wr_ptr] <= ent0;
        if (wr_n == 2'd2) mem[wr_ptr + PTR_ONE] <= ent1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            DATA_OUT   <= '0;
            DVALID_OUT <= 1'b0;
            PSYNC_OUT  <= 1'b0;
            BYTE_INDEX <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(wr_n);
            occ        <= occ + (PW+1)'(wr_n) - (PW+1)'(rd);
            DVALID_OUT <= rd;
            PSYNC_OUT  <= 1'b0;
            if (rd) begin
                {DATA_OUT, PSYNC_OUT, BYTE_INDEX} <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_output_ts_restore.sv
// tb/tb_output_ts_restore.sv - randomized scoreboard bench for output_ts_restore
module tb_output_ts_restore;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  DATA_IN = 8'h00;
    logic        DVALID_IN = 1'b0;
    logic        SOP_IN = 1'b0;
    logic        NM_or_HEM = 1'b0;
    logic [7:0]  DATA_OUT;
    logic        DVALID_OUT;
    logic        PSYNC_OUT;
    logic [7:0]  BYTE_INDEX;
    logic        CRC_ERR;
    logic        LEN_ERR;
    logic        OVF;
    logic [15:0] CRC_ERR_CNT;

    output_ts_restore #(.SYNC_BYTE(8'h47), .PKT_LEN(188), .BUF_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DVALID_IN(DVALID_IN), .SOP_IN(SOP_IN),
        .NM_or_HEM(NM_or_HEM), .DATA_OUT(DATA_OUT), .DVALID_OUT(DVALID_OUT),
        .PSYNC_OUT(PSYNC_OUT), .BYTE_INDEX(BYTE_INDEX), .CRC_ERR(CRC_ERR),
        .LEN_ERR(LEN_ERR), .OVF(OVF), .CRC_ERR_CNT(CRC_ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int n_vec = 0;
    int n_bad = 0;

    logic [16:0] exp_q[$];
    int          crc_q[$];
    int          len_q[$];
    int          ovf_q[$];

    bit          m_valid = 1'b0;
    bit          m_short = 1'b0;
    logic [7:0]  m_crc = 8'h00;
    int          exp_cnt = 0;
    bit          occ_model = 1'b0;
    int          m_occ = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic unexp(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got 1 expected 0 at cycle %0d", name, cyc);
    endtask

    // Remainder of M(x)*x^8 mod g(x) by long division over the whole message.
    function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
        logic [8:0] r;
        logic [7:0] b;
        r = '0;
        for (int i = 0; i <= msg.size(); i++) begin
            b = (i < msg.size()) ? msg[i] : 8'h00;
            for (int k = 7; k >= 0; k--) begin
                r = {r[7:0], b[k]};
                if (r[8]) r = r ^ 9'h1D5;
            end
        end
        return r[7:0];
    endfunction

    always @(negedge CLK) begin
        if (!RST) begin
            if (DVALID_OUT) begin
                if (exp_q.size() == 0) unexp("unexpected_output");
                else chk("out_byte", {DATA_OUT, PSYNC_OUT, BYTE_INDEX}, exp_q.pop_front());
            end
            if (CRC_ERR) begin
                if (crc_q.size() == 0) unexp("crc_err_pulse");
                else chk("crc_err_cycle", cyc, crc_q.pop_front());
            end
            if (LEN_ERR) begin
                if (len_q.size() == 0) unexp("len_err_pulse");
                else chk("len_err_cycle", cyc, len_q.pop_front());
            end
            if (OVF) begin
                if (ovf_q.size() == 0) unexp("ovf_pulse");
                else chk("ovf_cycle", cyc, ovf_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic sop, input logic mode);
        DATA_IN = d;
        SOP_IN = sop;
        NM_or_HEM = mode;
        DVALID_IN = 1'b1;
        @(posedge CLK);
        #1;
        DVALID_IN = 1'b0;
        SOP_IN = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
        if (occ_model) m_occ = (m_occ > n) ? m_occ - n : 0;
    endtask

    // cb: -1 correct CRC byte, -2 corrupted CRC byte, >=0 forced first byte (NM)
    task automatic send_pkt(input bit mode, input int len, input int cb, input bit extra,
                            input int gap, input bit zero);
        logic [7:0] pl[$];
        logic [7:0] first;
        int         full;
        bit         drop;
        full = mode ? 187 : 188;
        pl = {};
        for (int i = 0; i < (mode ? len : len - 1); i++) pl.push_back(zero ? 8'h00 : 8'($urandom));
        if (mode)                      first = pl[0];
        else if (cb >= 0)              first = 8'(cb);
        else if (m_valid && cb == -1)  first = m_crc;
        else if (m_valid)              first = m_crc ^ 8'($urandom_range(1, 255));
        else                           first = 8'($urandom);
        drop = 1'b0;
        if (occ_model && (DEPTH - m_occ + (m_occ > 0 ? 1 : 0) < (mode ? 2 : 1))) drop = 1'b1;
        if (m_short) len_q.push_back(cyc + 1);
        else if (!mode && m_valid && !drop && first != m_crc) begin
            crc_q.push_back(cyc + 1);
            exp_cnt++;
        end
        if (drop) ovf_q.push_back(cyc + 1);
        m_short = 1'b0;
        if (mode || drop) m_valid = 1'b0;
        if (!drop) begin
            exp_q.push_back({8'h47, 1'b1, 8'd1});
            for (int i = 0; i < pl.size(); i++) exp_q.push_back({pl[i], 1'b0, 8'(i + 2)});
        end
        send(first, 1'b1, mode);
        for (int i = (mode ? 1 : 0); i < pl.size(); i++) send(pl[i], 1'b0, mode);
        if (occ_model) begin
            if (drop) m_occ = (m_occ > len) ? m_occ - len : 0;
            else m_occ = m_occ + pl.size() + 1 - (m_occ > 0 ? len : len - 1);
        end
        if (!drop) begin
            if (len == full) begin
                if (!mode) begin
                    m_valid = 1'b1;
                    m_crc = crc_ref(pl);
                end
            end else begin
                m_short = 1'b1;
                m_valid = 1'b0;
            end
        end
        if (extra) begin
            if (!drop && len == full) begin
                len_q.push_back(cyc + 1);
                m_valid = 1'b0;
            end
            send(8'($urandom), 1'b0, mode);
        end
        idle(gap);
    endtask

    task automatic drain(input string ph);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge CLK);
            #1;
            t++;
        end
        idle(4);
        chk({ph, "_pending_out"}, exp_q.size(), 0);
        chk({ph, "_pending_crc_err"}, crc_q.size(), 0);
        chk({ph, "_pending_len_err"}, len_q.size(), 0);
        chk({ph, "_pending_ovf"}, ovf_q.size(), 0);
        chk({ph, "_crc_err_cnt"}, CRC_ERR_CNT, exp_cnt);
    endtask

    task automatic chk_zero(input string ph);
        chk({ph, "_data_out"}, DATA_OUT, 0);
        chk({ph, "_dvalid_out"}, DVALID_OUT, 0);
        chk({ph, "_psync_out"}, PSYNC_OUT, 0);
        chk({ph, "_byte_index"}, BYTE_INDEX, 0);
        chk({ph, "_crc_err"}, CRC_ERR, 0);
        chk({ph, "_len_err"}, LEN_ERR, 0);
        chk({ph, "_ovf"}, OVF, 0);
        chk({ph, "_crc_err_cnt"}, CRC_ERR_CNT, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int r, len, full, cb;
        bit mode, extra;
        repeat (2) @(posedge CLK);
        #1;
        chk_zero("reset");
        RST = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) send_pkt(1'b0, 188, (i == 0) ? 0 : -1, 1'b0, 0, 1'b1);
        send_pkt(1'b0, 188, 8'h5A, 1'b0, 2, 1'b1);
        drain("nm_zero");

        send_pkt(1'b1, 187, -1, 1'b0, 2, 1'b0);
        send_pkt(1'b1, 187, -1, 1'b0, 2, 1'b0);
        drain("hem");

        send_pkt(1'b0, 188, -1, 1'b0, 0, 1'b0);
        send_pkt(1'b0, 100, -1, 1'b0, 0, 1'b0);
        send_pkt(1'b0, 188, -2, 1'b0, 0, 1'b0);
        send_pkt(1'b0, 188, -1, 1'b1, 1, 1'b0);
        send_pkt(1'b0, 188, -2, 1'b0, 0, 1'b0);
        send_pkt(1'b0, 188, -2, 1'b0, 0, 1'b0);
        drain("nm_len");

        for (int p = 0; p < 16; p++) begin
            mode = 1'($urandom_range(0, 1));
            full = mode ? 187 : 188;
            r = $urandom_range(0, 99);
            len = (r < 15) ? $urandom_range(2, full - 1) : full;
            extra = (len == full) && (r >= 90);
            cb = ($urandom_range(0, 2) == 0) ? -2 : -1;
            send_pkt(mode, len, cb, extra, $urandom_range(1, 3), 1'b0);
        end
        drain("random");

        occ_model = 1'b1;
        m_occ = 0;
        for (int p = 0; p < 6; p++) send_pkt(1'b1, 187, -1, 1'b0, 0, 1'b0);
        occ_model = 1'b0;
        drain("hem_ovf");

        exp_q.push_back({8'h47, 1'b1, 8'd1});
        send(8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back({8'(i + 1), 1'b0, 8'(i + 2)});
            send(8'(i + 1), 1'b0, 1'b0);
        end
        RST = 1'b1;
        #1;
        chk_zero("mid_reset");
        exp_q.delete();
        crc_q.delete();
        len_q.delete();
        ovf_q.delete();
        m_valid = 1'b0;
        m_short = 1'b0;
        exp_cnt = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 1'b0);
        send_pkt(1'b0, 188, -2, 1'b0, 0, 1'b0);
        send_pkt(1'b0, 188, -2, 1'b0, 0, 1'b0);
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
